// File: rtl/wb_imem_loader.sv
// Wishbone slave that buffers program words and drains them into the Ibtida IMEM, holding the core in reset meanwhile.
// Optional CSUM register at offset 0x10 is built only when LOADER_CHECKSUM_EN is defined.
module wb_imem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 13,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wmask_o,
  input  logic                  mem_gnt_i,
  output logic                  core_rst_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 36;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_STAT = 3'd1;
  localparam logic [2:0] OFF_PTR  = 3'd2;
  localparam logic [2:0] OFF_DATA = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] OFF_CSUM = 3'd4;
`endif

  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]         IDX_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [EW-1:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_idx_r, rd_idx_r;
  logic [CW-1:0]         cnt_r;
  logic [1:0]            ctrl_r;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic                  wrap_r;
  logic [7:0]            err_r;
  logic                  ack_r;
  logic [31:0]           dat_r;
  logic [0:0]            state_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic [3:0]            mem_wmask_r;
  logic                  core_rst_r;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           csum_r;
`endif

  logic          req_s, hit_s, wr_s, data_wr_s, full_s, empty_s, pop_s;
  logic          stall_s, push_s, drop_s, busy_s, unused_s;
  logic [2:0]    off_s;
  logic [3:0]    level_s;
  logic [31:0]   rdata_s;
  logic [PW-1:0] rd_next_s;
  logic [EW-1:0] push_ent_s, head_s, next_head_s;

  assign req_s      = wbs_stb_i & wbs_cyc_i & ~ack_r;
  assign hit_s      = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign off_s      = wbs_adr_i[4:2];
  assign wr_s       = req_s & hit_s & wbs_we_i;
  assign data_wr_s  = wr_s & (off_s == OFF_DATA);
  assign full_s     = (cnt_r == CNT_FULL);
  assign empty_s    = (cnt_r == CNT_ZERO);
  assign pop_s      = (state_r == ST_REQ) & mem_gnt_i;
  // A full FIFO stalls the push, unless this very cycle frees the slot.
  assign stall_s    = data_wr_s & ctrl_r[1] & full_s & ~pop_s;
  assign push_s     = data_wr_s & ctrl_r[1] & ~stall_s;
  assign drop_s     = data_wr_s & ~ctrl_r[1];
  assign busy_s     = ~empty_s | (state_r == ST_REQ);
  assign level_s    = 4'(cnt_r);
  assign push_ent_s = {ptr_r, wbs_dat_i, wbs_sel_i};
  assign head_s     = fifo_mem_r[rd_idx_r];
  assign rd_next_s  = rd_idx_r + IDX_ONE;
  // With a single entry left, the follow-on head can only be the word pushed this cycle.
  assign next_head_s = (cnt_r > CNT_ONE) ? fifo_mem_r[rd_next_s] : push_ent_s;
  assign unused_s   = ^wbs_adr_i[1:0];

  // Register read mux.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (hit_s) begin
      case (off_s)
        OFF_CTRL: rdata_s = {30'h0, ctrl_r};
        OFF_STAT: rdata_s = {16'h0, err_r, 2'b00, wrap_r, busy_s, level_s};
        OFF_PTR:  rdata_s = {{(32-ADDR_WIDTH){1'b0}}, ptr_r};
`ifdef LOADER_CHECKSUM_EN
        OFF_CSUM: rdata_s = csum_r;
`endif
        default:  rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Single-cycle ack and registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else if (req_s && !stall_s) begin
      ack_r <= 1'b1;
      dat_r <= wbs_we_i ? 32'h0000_0000 : rdata_s;
    end else begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end
  end

  // Control, pointer and status registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_r <= 2'b01;
      ptr_r  <= {ADDR_WIDTH{1'b0}};
      wrap_r <= 1'b0;
      err_r  <= 8'h00;
    end else begin
      if (wr_s && off_s == OFF_CTRL) ctrl_r <= wbs_dat_i[1:0];
      if (wr_s && off_s == OFF_PTR) ptr_r <= wbs_dat_i[ADDR_WIDTH-1:0];
      else if (push_s) ptr_r <= ptr_r + PTR_ONE;
      if (wr_s && off_s == OFF_STAT) begin
        wrap_r <= 1'b0;
        err_r  <= 8'h00;
      end else begin
        if (push_s && (&ptr_r)) wrap_r <= 1'b1;
        if (drop_s && err_r != 8'hFF) err_r <= err_r + 8'h01;
      end
    end
  end

  // FIFO occupancy and indices.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_idx_r <= {PW{1'b0}};
      rd_idx_r <= {PW{1'b0}};
      cnt_r    <= CNT_ZERO;
    end else begin
      if (push_s) wr_idx_r <= wr_idx_r + IDX_ONE;
      if (pop_s) rd_idx_r <= rd_next_s;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge wb_clk_i) begin
    if (push_s) fifo_mem_r[wr_idx_r] <= push_ent_s;
  end

  // Drain FSM: present the head to IMEM until granted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
      mem_wmask_r <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            state_r <= ST_REQ;
            {mem_addr_r, mem_wdata_r, mem_wmask_r} <= head_s;
          end
        end
        ST_REQ: begin
          if (pop_s) begin
            if (cnt_r > CNT_ONE || push_s) begin
              {mem_addr_r, mem_wdata_r, mem_wmask_r} <= next_head_s;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Core reset stays asserted while HOLD is set or any word is still in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) core_rst_r <= 1'b1;
    else          core_rst_r <= ctrl_r[0] | busy_s;
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of drained words; a bus write overrides the pop update.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) csum_r <= 32'h0000_0000;
    else if (wr_s && off_s == OFF_CSUM) csum_r <= wbs_dat_i;
    else if (pop_s) csum_r <= csum_r + mem_wdata_r;
  end
`endif

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign mem_req_o   = (state_r == ST_REQ);
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_wmask_o = mem_wmask_r;
  assign core_rst_o  = core_rst_r;

endmodule

// File: tb/tb_wb_imem_loader.sv
// Directed bench for wb_imem_loader: register vector table plus drain, stall, error, wrap and reset sequences.
module tb_wb_imem_loader;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        mem_req_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i = 1'b0;
  logic        core_rst_o;

  int checks = 0;
  int failures = 0;
  logic [48:0] wq [$];
  logic        ack_prev = 1'b0;

  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_PTR  = 32'h3000_0008;
  localparam logic [31:0] A_DATA = 32'h3000_000C;
  localparam logic [31:0] A_CSUM = 32'h3000_0010;

  wb_imem_loader dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i), .core_rst_o(core_rst_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Record every granted IMEM write.
  always @(posedge wb_clk_i) begin
    if (!wb_rst_i && mem_req_o && mem_gnt_i) wq.push_back({mem_addr_o, mem_wdata_o, mem_wmask_o});
  end

  // ack must never be high two cycles running.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && wbs_ack_o && ack_prev) begin
      failures++;
      $display("FAIL ack_pulse: got two consecutive acks, want single-cycle");
    end
    ack_prev = wbs_ack_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat, output logic [31:0] rd);
    int n;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = 4'hF;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!wbs_ack_o && n < 20);
    check("bus_ack", {63'h0, wbs_ack_o}, 64'h1);
    rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    bus(1'b1, adr, dat, rd);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, adr, 32'h0, rd);
    check(name, {32'h0, rd}, {32'h0, exp});
  endtask

  task automatic exp_wr(input string name, input logic [12:0] a, input logic [31:0] d);
    logic [48:0] e;
    checks++;
    if (wq.size() == 0) begin
      failures++;
      $display("FAIL %s: got no IMEM write want addr 0x%0h data 0x%0h", name, a, d);
    end else begin
      e = wq.pop_front();
      if (e !== {a, d, 4'hF}) begin
        failures++;
        $display("FAIL %s: got 0x%0h want 0x%0h", name, e, {a, d, 4'hF});
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bit seen;
    int n;
    vecs[0]  = '{1'b0, A_CTRL,        32'h0, 32'h1};
    vecs[1]  = '{1'b0, A_STAT,        32'h0, 32'h0};
    vecs[2]  = '{1'b0, A_PTR,         32'h0, 32'h0};
    vecs[3]  = '{1'b0, A_DATA,        32'h0, 32'h0};
    vecs[4]  = '{1'b0, A_CSUM,        32'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_001C, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h3000_0020, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, A_PTR,         32'h0000_3ABC, 32'h0};
    vecs[8]  = '{1'b0, A_PTR,         32'h0, 32'h1ABC};
    vecs[9]  = '{1'b1, 32'h3000_0020, 32'h0000_0003, 32'h0};
    vecs[10] = '{1'b0, A_CTRL,        32'h0, 32'h1};
    vecs[11] = '{1'b1, 32'h2000_0000, 32'h0000_0002, 32'h0};
    vecs[12] = '{1'b0, A_CTRL,        32'h0, 32'h1};
    vecs[13] = '{1'b1, 32'h3000_0018, 32'h0000_0001, 32'h0};
    vecs[14] = '{1'b0, 32'h3000_0018, 32'h0, 32'h0};

    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_outputs", {mem_req_o, mem_addr_o, mem_wdata_o, mem_wmask_o, wbs_ack_o, wbs_dat_o}, 64'h0);
    check("rst_core_rst", {63'h0, core_rst_o}, 64'h1);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("core_rst_after_rst", {63'h0, core_rst_o}, 64'h1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) wr(vecs[i].adr, vecs[i].dat);
      else rd_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
    end

    // Drain with gnt held high.
    mem_gnt_i = 1'b1;
    wr(A_CTRL, 32'h3);
    wr(A_PTR, 32'h10);
    wr(A_DATA, 32'hA);
    wr(A_DATA, 32'hB);
    wr(A_DATA, 32'hC);
    repeat (8) @(posedge wb_clk_i); #1;
    exp_wr("drain0", 13'h10, 32'hA);
    exp_wr("drain1", 13'h11, 32'hB);
    exp_wr("drain2", 13'h12, 32'hC);
    rd_chk("ptr_after_drain", A_PTR, 32'h13);
    check("core_rst_hold", {63'h0, core_rst_o}, 64'h1);

    // Full FIFO stalls the fifth push until a pop.
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_DATA, 32'h100 + i);
    rd_chk("stat_full", A_STAT, 32'h14);
    check("held_addr", {51'h0, mem_addr_o}, 64'h13);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = A_DATA; wbs_dat_i = 32'h104;
    seen = 1'b0;
    repeat (5) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1'b1;
    end
    check("full_ack_withheld", {63'h0, seen}, 64'h0);
    mem_gnt_i = 1'b1;
    @(posedge wb_clk_i); #1;
    mem_gnt_i = 1'b0;
    check("full_ack_after_pop", {63'h0, wbs_ack_o}, 64'h1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    exp_wr("stall_pop", 13'h13, 32'h100);
    repeat (2) @(posedge wb_clk_i); #1;
    check("next_head_addr", {51'h0, mem_addr_o}, 64'h14);
    rd_chk("stat_refilled", A_STAT, 32'h14);
    mem_gnt_i = 1'b1;
    repeat (8) @(posedge wb_clk_i); #1;
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_wr($sformatf("stall_drain%0d", i), 13'h14 + 13'(i), 32'h101 + i);

    // EN=0 drops data and counts an error.
    wr(A_CTRL, 32'h0);
    wr(A_DATA, 32'hDEAD);
    repeat (4) @(posedge wb_clk_i); #1;
    check("dropped_no_req", {63'h0, mem_req_o}, 64'h0);
    check("dropped_no_write", 64'(wq.size()), 64'h0);
    rd_chk("stat_err", A_STAT, 32'h100);
    check("core_released", {63'h0, core_rst_o}, 64'h0);
    wr(A_STAT, 32'h0);
    rd_chk("stat_err_clr", A_STAT, 32'h0);
    rd_chk("ptr_not_advanced", A_PTR, 32'h18);

    // Pointer wrap, and HOLD cleared while busy.
    wr(A_CTRL, 32'h3);
    wr(A_PTR, 32'h1FFF);
    wr(A_DATA, 32'h55);
    wr(A_DATA, 32'h66);
    wr(A_CTRL, 32'h2);
    repeat (3) @(posedge wb_clk_i); #1;
    check("core_rst_busy", {63'h0, core_rst_o}, 64'h1);
    rd_chk("stat_wrap", A_STAT, 32'h32);
    mem_gnt_i = 1'b1;
    repeat (6) @(posedge wb_clk_i); #1;
    mem_gnt_i = 1'b0;
    exp_wr("wrap0", 13'h1FFF, 32'h55);
    exp_wr("wrap1", 13'h0000, 32'h66);
    check("core_rst_drained", {63'h0, core_rst_o}, 64'h0);
    rd_chk("ptr_wrapped", A_PTR, 32'h1);

`ifdef LOADER_CHECKSUM_EN
    wr(A_CSUM, 32'h0);
    mem_gnt_i = 1'b1;
    wr(A_DATA, 32'hFFFF_FFFF);
    wr(A_DATA, 32'h2);
    repeat (6) @(posedge wb_clk_i); #1;
    mem_gnt_i = 1'b0;
    rd_chk("csum", A_CSUM, 32'h1);
`else
    wr(A_CSUM, 32'h5);
    rd_chk("csum_unmapped", A_CSUM, 32'h0);
`endif
    wq.delete();

    // Asynchronous reset mid-request.
    wr(A_DATA, 32'h77);
    n = 0;
    while (!mem_req_o && n < 10) begin
      @(posedge wb_clk_i); #1; n++;
    end
    check("req_before_rst", {63'h0, mem_req_o}, 64'h1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("async_rst_req", {63'h0, mem_req_o}, 64'h0);
    check("async_rst_core", {63'h0, core_rst_o}, 64'h1);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    rd_chk("rst_ctrl", A_CTRL, 32'h1);
    rd_chk("rst_stat", A_STAT, 32'h0);
    rd_chk("rst_ptr", A_PTR, 32'h0);
    rd_chk("rst_csum", A_CSUM, 32'h0);
    repeat (3) @(posedge wb_clk_i); #1;
    check("rst_fifo_discarded", {63'h0, mem_req_o}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
